// File: rtl/run_stuffer_pkg.sv
// ----------------------------------------------------------------------------
// run_stuffer_pkg
//
// Shared definitions for the run-length bit stuffer:
//   - default word width and maximum run length
//   - FSM state encoding (IDLE / SHIFT / STUFF)
//   - per-cycle action encoding used by the top-level FSM and the run tracker
//   - width helper for counters
// ----------------------------------------------------------------------------
package run_stuffer_pkg;

    localparam int unsigned DEFAULT_DATA_W  = 8;
    localparam int unsigned DEFAULT_RUN_MAX = 3;

    // The state names what is on the line in the current cycle.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StStuff = 2'd2
    } state_e;

    // What the block does at the coming clock edge.
    typedef enum logic [1:0] {
        ActIdle  = 2'd0,  // drop to (or stay in) IDLE
        ActLoad  = 2'd1,  // capture in_data and drive its MSB
        ActShift = 2'd2,  // drive the next data bit of the current word
        ActStuff = 2'd3   // drive the complement of the last line bit
    } action_e;

    // Number of bits needed to hold the values 0..max_val.
    function automatic int unsigned width_for(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/run_tracker.sv
// ----------------------------------------------------------------------------
// run_tracker
//
// Tracks the run of identical bits on the serial line and flags when the
// bit currently on the line completes a run of RUN_MAX.
//
// Ports:
//   clk           in   clock, rising edge
//   reset         in   asynchronous reset, active low
//   clear         in   forget the run (line going idle)
//   data_en       in   a data bit is placed on the line at this edge
//   data_bit      in   value of that data bit
//   stuff_en      in   a stuff bit is placed on the line at this edge
//   last_bit      out  value of the bit currently on the line
//   stuff_needed  out  current line bit completed a run, next must be stuffed
// ----------------------------------------------------------------------------
module run_tracker
    import run_stuffer_pkg::*;
#(
    parameter int unsigned RUN_MAX = DEFAULT_RUN_MAX
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic data_en,
    input  logic data_bit,
    input  logic stuff_en,
    output logic last_bit,
    output logic stuff_needed
);

    localparam int unsigned RUN_W = width_for(RUN_MAX);

    logic             last_q;
    logic [RUN_W-1:0] run_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q    <= 1'b0;
            run_cnt_q <= '0;
        end else if (clear) begin
            last_q    <= 1'b0;
            run_cnt_q <= '0;
        end else if (stuff_en) begin
            // A stuff bit starts a fresh run of its own value.
            last_q    <= ~last_q;
            run_cnt_q <= RUN_W'(1);
        end else if (data_en) begin
            // run_cnt_q == 0 means nothing has been sent since idle.
            if (run_cnt_q != '0 && data_bit == last_q) begin
                run_cnt_q <= run_cnt_q + RUN_W'(1);
            end else begin
                run_cnt_q <= RUN_W'(1);
            end
            last_q <= data_bit;
        end
    end

    assign last_bit     = last_q;
    assign stuff_needed = (run_cnt_q == RUN_W'(RUN_MAX));

endmodule

// File: rtl/run_stuffer.sv
// ----------------------------------------------------------------------------
// run_stuffer
//
// Serialises DATA_W-bit words MSB first onto a one-bit line and inserts the
// complement of the previous bit after every RUN_MAX identical line bits.
// A new word may be accepted while the final bit of the previous word is on
// the line, giving gap-free back-to-back transmission with the run carried
// across the word boundary.
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   asynchronous reset, active low
//   in_data   in   DATA_W  word to transmit, MSB first
//   in_valid  in   in_data valid
//   in_ready  out  in_data accepted this cycle if in_valid is high
//   y         out  serial line bit
//   y_valid   out  y carries a data or stuff bit
//   y_stuff   out  y is an inserted stuff bit
//   busy      out  FSM not in IDLE
// ----------------------------------------------------------------------------
module run_stuffer
    import run_stuffer_pkg::*;
#(
    parameter int unsigned DATA_W  = DEFAULT_DATA_W,
    parameter int unsigned RUN_MAX = DEFAULT_RUN_MAX
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              y,
    output logic              y_valid,
    output logic              y_stuff,
    output logic              busy
);

    localparam int unsigned CNT_W = width_for(DATA_W - 1);

    state_e            state_q;
    logic [DATA_W-1:0] shreg_q;    // remaining data bits, next one at the MSB
    logic [CNT_W-1:0]  bit_cnt_q;  // data bits still to send after the current one
    logic              y_q;
    logic              y_valid_q;
    logic              y_stuff_q;

    logic    accept;
    logic    bits_left;
    logic    last_bit;
    logic    stuff_needed;
    action_e action;

    logic trk_clear;
    logic trk_data_en;
    logic trk_data_bit;
    logic trk_stuff_en;

    assign bits_left = (bit_cnt_q != '0);
    assign accept    = in_valid & in_ready;

    // Ready when the current line bit is the last one the current word needs.
    always_comb begin
        in_ready = 1'b0;
        unique case (state_q)
            StIdle:  in_ready = 1'b1;
            StShift: in_ready = !bits_left && !stuff_needed;
            StStuff: in_ready = !bits_left;
            default: in_ready = 1'b1;
        endcase
    end

    // Decide what happens at the next edge; shared by the FSM and the tracker.
    always_comb begin
        action = ActIdle;
        unique case (state_q)
            StIdle: begin
                if (accept) action = ActLoad;
            end
            StShift: begin
                if (stuff_needed)   action = ActStuff;
                else if (bits_left) action = ActShift;
                else if (accept)    action = ActLoad;
                else                action = ActIdle;
            end
            StStuff: begin
                if (bits_left)   action = ActShift;
                else if (accept) action = ActLoad;
                else             action = ActIdle;
            end
            default: action = ActIdle;
        endcase
    end

    always_comb begin
        trk_clear    = 1'b0;
        trk_data_en  = 1'b0;
        trk_data_bit = 1'b0;
        trk_stuff_en = 1'b0;
        unique case (action)
            ActIdle: trk_clear = 1'b1;
            ActLoad: begin
                trk_data_en  = 1'b1;
                trk_data_bit = in_data[DATA_W-1];
            end
            ActShift: begin
                trk_data_en  = 1'b1;
                trk_data_bit = shreg_q[DATA_W-1];
            end
            ActStuff: trk_stuff_en = 1'b1;
            default:  trk_clear = 1'b1;
        endcase
    end

    run_tracker #(
        .RUN_MAX (RUN_MAX)
    ) u_run_tracker (
        .clk          (clk),
        .reset        (reset),
        .clear        (trk_clear),
        .data_en      (trk_data_en),
        .data_bit     (trk_data_bit),
        .stuff_en     (trk_stuff_en),
        .last_bit     (last_bit),
        .stuff_needed (stuff_needed)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            y_q       <= 1'b0;
            y_valid_q <= 1'b0;
            y_stuff_q <= 1'b0;
        end else begin
            unique case (action)
                ActLoad: begin
                    state_q   <= StShift;
                    y_q       <= in_data[DATA_W-1];
                    shreg_q   <= {in_data[DATA_W-2:0], 1'b0};
                    bit_cnt_q <= CNT_W'(DATA_W - 1);
                    y_valid_q <= 1'b1;
                    y_stuff_q <= 1'b0;
                end
                ActShift: begin
                    state_q   <= StShift;
                    y_q       <= shreg_q[DATA_W-1];
                    shreg_q   <= {shreg_q[DATA_W-2:0], 1'b0};
                    bit_cnt_q <= bit_cnt_q - CNT_W'(1);
                    y_valid_q <= 1'b1;
                    y_stuff_q <= 1'b0;
                end
                ActStuff: begin
                    // Word position is held; only the line bit changes.
                    state_q   <= StStuff;
                    y_q       <= ~last_bit;
                    y_valid_q <= 1'b1;
                    y_stuff_q <= 1'b1;
                end
                ActIdle: begin
                    state_q   <= StIdle;
                    shreg_q   <= '0;
                    bit_cnt_q <= '0;
                    y_q       <= 1'b0;
                    y_valid_q <= 1'b0;
                    y_stuff_q <= 1'b0;
                end
                default: begin
                    state_q   <= StIdle;
                    y_valid_q <= 1'b0;
                    y_stuff_q <= 1'b0;
                    y_q       <= 1'b0;
                end
            endcase
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign y_stuff = y_stuff_q;
    assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_run_stuffer.sv
module tb_run_stuffer;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned RUN_MAX = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              y;
    logic              y_valid;
    logic              y_stuff;
    logic              busy;

    run_stuffer #(
        .DATA_W  (DATA_W),
        .RUN_MAX (RUN_MAX)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .y        (y),
        .y_valid  (y_valid),
        .y_stuff  (y_stuff),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model: expected line stream ----------------
    typedef struct packed {
        logic b;
        logic s;
    } lbit_t;

    lbit_t             line_q[$];  // front = bit expected on the line now
    logic [DATA_W-1:0] sent_q[$];  // accepted words awaiting de-stuffing
    logic              m_last = 1'b0;
    int                m_run  = 0;

    task automatic expand(input logic [DATA_W-1:0] d);
        lbit_t e;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (m_run > 0 && d[i] == m_last) m_run++;
            else m_run = 1;
            m_last = d[i];
            e.b = d[i];
            e.s = 1'b0;
            line_q.push_back(e);
            if (m_run == RUN_MAX) begin
                e.b = ~d[i];
                e.s = 1'b1;
                line_q.push_back(e);
                m_last = ~d[i];
                m_run = 1;
            end
        end
    endtask

    // ---------------- DUT stream monitors ----------------
    logic [DATA_W-1:0] rx_word = '0;
    int                rx_cnt  = 0;
    logic              dut_last = 1'b0;
    int                dut_run  = 0;
    int                rec_n    = 0;
    int                rec_rdy  = 0;
    logic [31:0]       rec_bits = '0;
    logic [31:0]       rec_stuff = '0;

    task automatic rec_clear();
        rec_n = 0;
        rec_rdy = 0;
        rec_bits = '0;
        rec_stuff = '0;
    endtask

    task automatic observe();
        logic exp_v;
        exp_v = (line_q.size() > 0);
        check("y_valid", y_valid, exp_v);
        check("busy", busy, exp_v);
        check("in_ready", in_ready, line_q.size() <= 1);
        if (exp_v) begin
            check("y", y, line_q[0].b);
            check("y_stuff", y_stuff, line_q[0].s);
        end else begin
            check("y_idle", y, 1'b0);
            check("y_stuff_idle", y_stuff, 1'b0);
        end
        if (y_valid) begin
            rec_n++;
            rec_bits = {rec_bits[30:0], y};
            rec_stuff = {rec_stuff[30:0], y_stuff};
            if (in_ready) rec_rdy++;
            if (dut_run > 0 && y == dut_last) dut_run++;
            else dut_run = 1;
            dut_last = y;
            check("run_len", dut_run <= RUN_MAX, 1'b1);
            if (!y_stuff) begin
                rx_word = {rx_word[DATA_W-2:0], y};
                rx_cnt++;
                if (rx_cnt == DATA_W) begin
                    rx_cnt = 0;
                    if (sent_q.size() == 0) check("sb_extra_word", rx_word, '1);
                    else check("sb_word", rx_word, sent_q.pop_front());
                end
            end
        end else begin
            dut_run = 0;
        end
    endtask

    // Called at posedge+1: drive inputs, advance one edge, update model, check.
    task automatic step(input logic v, input logic [DATA_W-1:0] d, output logic accepted);
        logic from_idle;
        in_valid = v;
        in_data = d;
        from_idle = (line_q.size() == 0);
        accepted = v && (line_q.size() <= 1);
        @(posedge clk);
        if (line_q.size() > 0) void'(line_q.pop_front());
        if (accepted) begin
            if (from_idle) m_run = 0;
            expand(d);
            sent_q.push_back(d);
        end
        #1;
        observe();
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 64 && line_q.size() > 0; i++) step(1'b0, '0, acc);
        step(1'b0, '0, acc);
        check("drain_idle", y_valid, 1'b0);
    endtask

    task automatic directed(input string name, input logic [DATA_W-1:0] d, input int exp_len,
                            input logic [31:0] exp_bits, input logic [31:0] exp_stuff);
        logic acc;
        rec_clear();
        step(1'b1, d, acc);
        check({name, "_accept"}, acc, 1'b1);
        drain();
        check({name, "_len"}, rec_n, exp_len);
        check({name, "_bits"}, rec_bits, exp_bits);
        check({name, "_stuff"}, rec_stuff, exp_stuff);
    endtask

    initial begin
        logic acc;
        int   n_acc;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_y", y, 1'b0);
        check("rst_y_valid", y_valid, 1'b0);
        check("rst_y_stuff", y_stuff, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        reset = 1'b1;
        step(1'b0, '0, acc);

        // Directed patterns
        directed("aa", 8'hAA, 8, 32'h0AA, 32'h000);
        rec_clear();
        step(1'b1, 8'hFF, acc);
        drain();
        check("ff_len", rec_n, 10);
        check("ff_bits", rec_bits, 32'h3BB);
        check("ff_stuff", rec_stuff, 32'h044);
        check("ff_ready_cycles", rec_rdy, 1);
        directed("e3", 8'hE3, 10, 32'h38B, 32'h048);

        // Back-to-back 0x00 words: run carries across the boundary
        rec_clear();
        step(1'b1, 8'h00, acc);
        n_acc = 0;
        for (int i = 0; i < 20 && n_acc == 0; i++) begin
            step(1'b1, 8'h00, acc);
            if (acc) n_acc++;
        end
        check("zz_second_accept", n_acc, 1);
        drain();
        check("zz_len", rec_n, 21);
        check("zz_bits", rec_bits, 32'b000100010001000100010);
        check("zz_stuff", rec_stuff, 32'b000100010001000100010);

        // Reset in the middle of 0xFF
        step(1'b1, 8'hFF, acc);
        repeat (4) step(1'b0, '0, acc);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_y_valid", y_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_y", y, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        line_q.delete();
        sent_q.delete();
        m_run = 0;
        rx_cnt = 0;
        dut_run = 0;
        @(posedge clk);
        #1;
        check("midrst_hold_busy", busy, 1'b0);
        reset = 1'b1;
        directed("aa_after_rst", 8'hAA, 8, 32'h0AA, 32'h000);

        // Continuous valid with random data
        for (int i = 0; i < 400; i++) step(1'b1, DATA_W'($urandom()), acc);
        drain();

        // Random valid with random data
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, DATA_W'($urandom()), acc);
        drain();
        check("sb_leftover", sent_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/run_stuffer.md
RUN_STUFFER -- requirements
Module: run_stuffer

Interface
REQ-001 Parameter: DATA_W, default 8, byte width serialized per load (DATA_W >= 2).
REQ-002 Parameter: RUN_MAX, default 3, longest permitted run of identical line bits (RUN_MAX >= 2).
REQ-003 Port: clk  input  1  single clock, all state on rising edge.
REQ-004 Port: reset  input  1  reset, asynchronous, active-low.
REQ-005 Port: in_data  input  DATA_W  parallel word to transmit, MSB first.
REQ-006 Port: in_valid  input  1  in_data valid.
REQ-007 Port: in_ready  output  1  block accepts in_data this cycle.
REQ-008 Port: y  output  1  serial line bit.
REQ-009 Port: y_valid  output  1  y carries a data or stuff bit this cycle.
REQ-010 Port: y_stuff  output  1  current y is an inserted stuff bit.
REQ-011 Port: busy  output  1  state is not IDLE.

Function
REQ-012 The block SHALL emit each accepted word MSB first, one bit per cycle, and SHALL insert the complement of the previous bit whenever RUN_MAX identical consecutive bits have been emitted.
REQ-013 A transfer SHALL occur on a rising edge when in_valid and in_ready are both high; in_data SHALL be captured at that edge.
REQ-014 Latency: the first bit of a word accepted at edge t SHALL be driven on y with y_valid high in the cycle following edge t.
REQ-015 States: IDLE (y_valid=0, in_ready=1), SHIFT (emit data bit), STUFF (emit stuff bit).
REQ-016 IDLE->SHIFT on transfer; SHIFT->STUFF when the emitted bit makes the run count equal RUN_MAX; SHIFT->SHIFT otherwise while data bits remain.
REQ-017 STUFF->SHIFT if data bits remain, or if a new word is accepted while STUFF emits the word's final stuff bit; otherwise ->IDLE.
REQ-018 After the last data bit with no stuff pending, the next state SHALL be SHIFT if a new word is accepted in that cycle, otherwise IDLE.
REQ-019 in_ready SHALL be high in IDLE, in SHIFT while emitting the last data bit when that bit does not complete a run, and in STUFF when no data bits remain; otherwise low.
REQ-020 Run tracking: each data bit equal to the last line bit SHALL increment run_cnt; a differing bit SHALL set run_cnt=1; a stuff bit SHALL set last bit to itself and run_cnt=1.
REQ-021 A stuff bit SHALL never itself trigger further stuffing.
REQ-022 Run state SHALL carry across back-to-back words with no idle gap, and SHALL clear (run_cnt=0) on entering IDLE.
REQ-023 In IDLE y SHALL be 0 and y_stuff 0; y_stuff SHALL be high only in STUFF.
REQ-024 in_valid while in_ready is low SHALL be ignored; in_data SHALL not be sampled.
REQ-025 A word with no stuffing SHALL occupy exactly DATA_W line cycles; each stuff bit SHALL add one cycle.

Reset
REQ-026 While reset is low: state=IDLE, run_cnt=0, bit counter=0, shift register=0, in_ready=1, y=0, y_valid=0, y_stuff=0, busy=0.
REQ-027 Reset asserted mid-word SHALL abandon the word immediately without completing or stuffing it; the first edge after release SHALL be able to accept a new word.

Structure
REQ-028 State encoding (IDLE, SHIFT, STUFF) and default DATA_W/RUN_MAX constants SHALL reside in the shared FSM package.
REQ-029 Run counting (last bit, run_cnt, stuff-needed flag) SHALL be a sub-module named run_tracker; the rest stays flat in run_stuffer.

Verification
REQ-030 0xAA loaded from IDLE -> y=1,0,1,0,1,0,1,0 over 8 cycles, y_stuff never high, then IDLE.
REQ-031 0xFF -> y=1,1,1,0*,1,1,1,0*,1,1 (* = y_stuff high), 10 cycles, in_ready high only on the final bit.
REQ-032 0x00 then 0x00 back-to-back -> 21 line bits with no gap, 5 stuff bits; the second word begins 0,1* because the run carries over.
REQ-033 0xE3 -> y=1,1,1,0*,0,0,1*,0,1,1, 10 cycles.
REQ-034 Reset low on bit 4 of 0xFF -> y_valid=0, busy=0 in the same cycle; 0xAA accepted after release -> clean 8-bit output, no stuffing.
REQ-035 in_valid held high continuously with random data -> no line gaps, no run longer than RUN_MAX, and the scoreboard (de-stuffed stream) matches the input words.
